serial_frame_tx: RTL and testbench

Serial frame transmitter, the sending end of the lab's serial link. It accepts a 2-bit port number and a parallel data word. It then shifts them out on a single line, one bit per clock-enable tick: start bit, port MSB-first, data MSB-first, stop bit. It sits between the parallel test source and the serial line feeding the receiver's port/data counters.

---
 rtl/serial_frame_tx.sv | 83 ++++++++
 tb/tb_serial_frame_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: shifts out start bit, 2-bit port and DATA_BITS data word MSB-first, then a stop bit,
// advancing one bit per clkEn tick.
module serial_frame_tx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clkEn,
    input  logic                 start,
    input  logic [1:0]           port,
    input  logic [DATA_BITS-1:0] data,
    output logic                 serOut,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(DATA_BITS) + 1;
    localparam int SW = DATA_BITS + 2;
    typedef enum logic [2:0] {IDLE, START, PORT, DATA, STOP} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sh_q, sh_d;
    logic          ser_q, ser_d, busy_q, busy_d, done_q, done_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        if (clkEn) begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = START;
                    sh_d    = {port, data};
                end
                START: begin
                    state_d = PORT;
                    cnt_d   = '0;
                end
                PORT: begin
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(DATA_BITS - 1)) state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        // outputs are precomputed from next state so they leave flops directly
        busy_d = state_d != IDLE;
        ser_d  = (state_d == START) ? 1'b0 :
                 (state_d == PORT || state_d == DATA) ? sh_d[SW-1] : 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            ser_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign serOut = ser_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: random and directed frames checked every cycle against a bit-list frame model.
module tb_serial_frame_tx;
    localparam int DB = 8;
    logic          clk = 1'b0, rst = 1'b0, clkEn = 1'b0, start = 1'b0;
    logic [1:0]    port = '0;
    logic [DB-1:0] data = '0;
    logic          serOut, busy, done;
    int            n_chk = 0, n_fail = 0, tick_n = 0, m_pos = -1;
    logic          m_done = 1'b0, m_ser;
    logic          m_bits [DB+4];
    int            done_ticks [$];
    logic          lit [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    serial_frame_tx #(.DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .clkEn(clkEn), .start(start), .port(port), .data(data),
        .serOut(serOut), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: a frame is the list of line levels after each tick, indexed by ticks since accept
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos  <= -1;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (clkEn) begin
                tick_n <= tick_n + 1;
                if (m_pos < 0) begin
                    if (start) begin
                        m_pos     <= 0;
                        m_bits[0] <= 1'b0;
                        m_bits[1] <= port[1];
                        m_bits[2] <= port[0];
                        for (int i = 0; i < DB; i++) m_bits[3+i] <= data[DB-1-i];
                        m_bits[DB+3] <= 1'b1;
                    end
                end else if (m_pos == DB + 3) begin
                    m_pos  <= -1;
                    m_done <= 1'b1;
                end else m_pos <= m_pos + 1;
            end
        end
    end

    always_comb m_ser = (m_pos < 0) ? 1'b1 : m_bits[m_pos];

    always @(negedge clk) begin
        chk("serOut", 32'(serOut), 32'(m_ser));
        chk("busy", 32'(busy), 32'(m_pos >= 0));
        chk("done", 32'(done), 32'(m_done));
        if (done) done_ticks.push_back(tick_n);
    end

    // gap idle cycles with random start (must be ignored), then one tick cycle
    task automatic tick(input logic s, input int gap);
        repeat (gap) begin
            @(negedge clk);
            clkEn = 1'b0;
            start = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        clkEn = 1'b1;
        start = s;
        @(negedge clk);
        clkEn = 1'b0;
        start = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        clkEn = 1'b1;
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_serOut", 32'(serOut), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        clkEn = 1'b0;
        #3 rst = 1'b0;
    endtask

    initial begin
        int base, busy_t, b2b;
        #1 rst = 1'b1;
        #1;
        chk("init_serOut", 32'(serOut), 32'd1);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        @(negedge clk);
        #3 rst = 1'b0;

        // basic frame, one tick per 4 clocks, inputs changed after accept, extra start at tick 5
        port   = 2'b10;
        data   = 8'hA5;
        base   = done_ticks.size();
        busy_t = 0;
        for (int t = 0; t < 12; t++) begin
            tick(t == 0 || t == 5, 3);
            if (t == 0) begin
                port = 2'b01;
                data = 8'h3C;
            end
            chk("basic_ser_lit", 32'(serOut), 32'(lit[t]));
            chk("model_ser_lit", 32'(m_ser), 32'(lit[t]));
            busy_t += int'(busy);
        end
        tick(1'b0, 3);
        chk("busy_ticks", 32'(busy_t), 32'd12);
        chk("done_at_t12", 32'(done), 32'd1);
        chk("busy_at_t12", 32'(busy), 32'd0);
        chk("ser_at_t12", 32'(serOut), 32'd1);
        repeat (4) tick(1'b0, 3);
        chk("basic_one_done", 32'(done_ticks.size() - base), 32'd1);

        // back-to-back with start held
        port = 2'b11;
        data = 8'hFF;
        base = done_ticks.size();
        b2b  = 0;
        while (b2b < 40 && done_ticks.size() < base + 2) begin
            tick(1'b1, 1);
            if (b2b == 0) data = 8'h00;
            b2b++;
        end
        chk("b2b_dones", 32'(done_ticks.size() - base), 32'd2);
        if (done_ticks.size() >= base + 2)
            chk("b2b_spacing", 32'(done_ticks[base+1] - done_ticks[base]), 32'd13);
        repeat (16) tick(1'b0, 1);

        // stall 20 clocks in DATA
        port = 2'b01;
        data = 8'h96;
        base = done_ticks.size();
        tick(1'b1, 1);
        for (int t = 1; t < 16; t++) tick(1'b0, (t == 6) ? 20 : 1);
        chk("stall_done", 32'(done_ticks.size() - base), 32'd1);

        // abort at tick 6, then a fresh frame
        port = 2'b10;
        data = 8'h5A;
        base = done_ticks.size();
        tick(1'b1, 2);
        repeat (5) tick(1'b0, 2);
        mid_reset();
        repeat (16) tick(1'b0, 1);
        chk("abort_no_done", 32'(done_ticks.size() - base), 32'd0);
        port = 2'b01;
        data = 8'hC3;
        tick(1'b1, 2);
        repeat (14) tick(1'b0, 2);
        chk("after_abort_done", 32'(done_ticks.size() - base), 32'd1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            port = 2'($urandom_range(0, 3));
            data = DB'($urandom);
            tick(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        repeat (16) tick(1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
